// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer: FSM states, the note
// frequency table and the note-index width.
package note_seq_pkg;

  localparam int NOTE_IDX_W = 3;
  localparam int NUM_NOTES  = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MANUAL    = 2'd1,
    ST_AUTO_NOTE = 2'd2,
    ST_AUTO_GAP  = 2'd3
  } seq_state_e;

  // C5 major scale up to C6, in Hz
  localparam int unsigned NOTE_FREQ_HZ [NUM_NOTES] = '{
    523, 587, 659, 698, 783, 880, 987, 1046
  };

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/note_rom.sv
// Combinational note-index to divider-period lookup; every entry folds to a
// constant CLK_HZ / f at elaboration, so no runtime divider is built.
module note_rom
  import note_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic [NOTE_IDX_W-1:0] idx,
  output logic [31:0]           divisor
);

  always_comb begin
    divisor = '0;
    case (idx)
      3'd0: divisor = 32'(CLK_HZ / NOTE_FREQ_HZ[0]);
      3'd1: divisor = 32'(CLK_HZ / NOTE_FREQ_HZ[1]);
      3'd2: divisor = 32'(CLK_HZ / NOTE_FREQ_HZ[2]);
      3'd3: divisor = 32'(CLK_HZ / NOTE_FREQ_HZ[3]);
      3'd4: divisor = 32'(CLK_HZ / NOTE_FREQ_HZ[4]);
      3'd5: divisor = 32'(CLK_HZ / NOTE_FREQ_HZ[5]);
      3'd6: divisor = 32'(CLK_HZ / NOTE_FREQ_HZ[6]);
      3'd7: divisor = 32'(CLK_HZ / NOTE_FREQ_HZ[7]);
      default: divisor = '0;
    endcase
  end

endmodule

// File: rtl/note_sequencer.sv
// Manual / automatic scale player producing a period for a downstream clock
// divider. Define NOTE_SEQ_GAP_EN to insert a silent AUTO_GAP between auto notes.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned NOTE_TICKS = 25000000,
  parameter int unsigned GAP_TICKS  = 2500000
) (
  input  logic                  inclk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  auto_mode,
  input  logic [NOTE_IDX_W-1:0] sw_note,
  output logic [31:0]           divisor,
  output logic                  tone_en,
  output logic [NOTE_IDX_W-1:0] note_idx,
  output logic                  note_change,
  output logic [1:0]            state_dbg
);

  localparam int unsigned CNT_MAX = max_u(NOTE_TICKS, GAP_TICKS);
  localparam int          CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
`ifdef NOTE_SEQ_GAP_EN
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
`endif

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NOTE_IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic [31:0]           divisor_q, divisor_d;
  logic                  tone_en_q, tone_en_d;
  logic [NOTE_IDX_W-1:0] note_idx_q, note_idx_d;
  logic                  note_change_q, note_change_d;
  logic [NOTE_IDX_W-1:0] rom_idx;
  logic [31:0]           rom_div;

  note_rom #(.CLK_HZ(CLK_HZ)) u_rom (
    .idx     (rom_idx),
    .divisor (rom_div)
  );

  // Next-state: play low wins over everything, then mode changes, then counting.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_idx_d = cur_idx_q;
    if (!play) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = auto_mode ? ST_AUTO_NOTE : ST_MANUAL;
          cnt_d   = '0;
        end
        ST_MANUAL: begin
          cur_idx_d = sw_note;
          if (auto_mode) begin
            state_d = ST_AUTO_NOTE;
            cnt_d   = '0;
          end
        end
        ST_AUTO_NOTE: begin
          if (!auto_mode) begin
            state_d = ST_MANUAL;
            cnt_d   = '0;
          end else if (cnt_q == NOTE_LAST) begin
            cnt_d     = '0;
            cur_idx_d = cur_idx_q + 1'b1;
`ifdef NOTE_SEQ_GAP_EN
            state_d   = ST_AUTO_GAP;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef NOTE_SEQ_GAP_EN
        ST_AUTO_GAP: begin
          if (!auto_mode) begin
            state_d = ST_MANUAL;
            cnt_d   = '0;
          end else if (cnt_q == GAP_LAST) begin
            state_d = ST_AUTO_NOTE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs follow the current state one register later; play low silences at once.
  always_comb begin
    rom_idx     = (state_q == ST_MANUAL) ? sw_note : cur_idx_q;
    divisor_d   = '0;
    tone_en_d   = 1'b0;
    note_idx_d  = cur_idx_q;
    if (play && ((state_q == ST_MANUAL) || (state_q == ST_AUTO_NOTE))) begin
      divisor_d  = rom_div;
      tone_en_d  = 1'b1;
      note_idx_d = rom_idx;
    end
    note_change_d = (divisor_d != divisor_q) || (tone_en_d != tone_en_q);
  end

  always_ff @(posedge inclk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cur_idx_q     <= '0;
      divisor_q     <= '0;
      tone_en_q     <= 1'b0;
      note_idx_q    <= '0;
      note_change_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_idx_q     <= cur_idx_d;
      divisor_q     <= divisor_d;
      tone_en_q     <= tone_en_d;
      note_idx_q    <= note_idx_d;
      note_change_q <= note_change_d;
    end
  end

  assign divisor     = divisor_q;
  assign tone_en     = tone_en_q;
  assign note_idx    = note_idx_q;
  assign note_change = note_change_q;
  assign state_dbg   = state_q;

endmodule
